// File: rtl/ant_pkg.sv
// Shared ANT serial protocol constants and the receive-parser state type.
package ant_pkg;

  localparam logic [7:0] MESG_TX_SYNC              = 8'hA4;
  localparam logic [7:0] MESG_SYSTEM_RESET_ID      = 8'h4A;
  localparam logic [7:0] MESG_BROADCAST_DATA_ID    = 8'h4E;
  localparam logic [7:0] MESG_ACKNOWLEDGED_DATA_ID = 8'h4F;
  localparam logic [7:0] MESG_CHANNEL_EVENT_ID     = 8'h40;
  localparam logic [7:0] MESG_STARTUP_ID           = 8'h6F;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_LEN,
    RX_ID,
    RX_DATA,
    RX_CSUM
  } ant_rx_state_t;

endpackage

// File: rtl/ant_rx_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module ant_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holds at LAST so a stalled consumer never sees the count wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/ant_rx_parser.sv
// ANT serial receive parser: sync/len/id/data/checksum framing with timeout.
// Optional statistics counters built only when ANT_RX_STATS_EN is defined.
module ant_rx_parser
  import ant_pkg::*;
#(
  parameter int MAX_LEN        = 13,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                 c50m,
  input  logic                 nRST,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 msg_valid,
  output logic [7:0]           msg_id,
  output logic [7:0]           msg_len,
  output logic [MAX_LEN*8-1:0] msg_data,
  output logic                 err_checksum,
  output logic                 err_length,
  output logic                 err_timeout,
  output logic                 busy,
  output logic [15:0]          good_count,
  output logic [15:0]          err_count
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  ant_rx_state_t        state_q, state_d;
  logic [7:0]           len_q, len_d, id_q, id_d, idx_q, idx_d, xor_q, xor_d;
  logic [MAX_LEN*8-1:0] buf_q, buf_d;
  logic [7:0]           msg_id_q, msg_id_d, msg_len_q, msg_len_d;
  logic [MAX_LEN*8-1:0] msg_data_q, msg_data_d;
  logic                 msg_valid_q, msg_valid_d;
  logic                 err_checksum_q, err_checksum_d;
  logic                 err_length_q, err_length_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 expire;

  ant_rx_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (c50m),
    .rst_n  (nRST),
    .clear  (rx_valid || (state_q == RX_IDLE)),
    .enable (state_q != RX_IDLE),
    .expire (expire)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    id_d           = id_q;
    idx_d          = idx_q;
    xor_d          = xor_q;
    buf_d          = buf_q;
    msg_id_d       = msg_id_q;
    msg_len_d      = msg_len_q;
    msg_data_d     = msg_data_q;
    msg_valid_d    = 1'b0;
    err_checksum_d = 1'b0;
    err_length_d   = 1'b0;
    err_timeout_d  = 1'b0;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (rx_valid) begin
      unique case (state_q)
        RX_IDLE: begin
          if (rx_byte == MESG_TX_SYNC) begin
            state_d = RX_LEN;
            xor_d   = MESG_TX_SYNC;
            buf_d   = '0;
            idx_d   = '0;
          end
        end
        RX_LEN: begin
          if (rx_byte > MAX_LEN_B) begin
            err_length_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            len_d   = rx_byte;
            xor_d   = xor_q ^ rx_byte;
            state_d = RX_ID;
          end
        end
        RX_ID: begin
          id_d    = rx_byte;
          xor_d   = xor_q ^ rx_byte;
          state_d = (len_q != 8'd0) ? RX_DATA : RX_CSUM;
        end
        RX_DATA: begin
          for (int k = 0; k < MAX_LEN; k++) begin
            if (idx_q == 8'(k)) buf_d[k*8 +: 8] = rx_byte;
          end
          xor_d = xor_q ^ rx_byte;
          idx_d = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) state_d = RX_CSUM;
        end
        RX_CSUM: begin
          if (rx_byte == xor_q) begin
            msg_id_d    = id_q;
            msg_len_d   = len_q;
            msg_data_d  = buf_q;
            msg_valid_d = 1'b1;
          end else begin
            err_checksum_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (expire) begin
      err_timeout_d = 1'b1;
      state_d       = RX_IDLE;
    end
  end

  always_ff @(posedge c50m or negedge nRST) begin
    if (!nRST) begin
      state_q        <= RX_IDLE;
      len_q          <= '0;
      id_q           <= '0;
      idx_q          <= '0;
      xor_q          <= '0;
      buf_q          <= '0;
      msg_id_q       <= '0;
      msg_len_q      <= '0;
      msg_data_q     <= '0;
      msg_valid_q    <= 1'b0;
      err_checksum_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      id_q           <= id_d;
      idx_q          <= idx_d;
      xor_q          <= xor_d;
      buf_q          <= buf_d;
      msg_id_q       <= msg_id_d;
      msg_len_q      <= msg_len_d;
      msg_data_q     <= msg_data_d;
      msg_valid_q    <= msg_valid_d;
      err_checksum_q <= err_checksum_d;
      err_length_q   <= err_length_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign msg_valid    = msg_valid_q;
  assign msg_id       = msg_id_q;
  assign msg_len      = msg_len_q;
  assign msg_data     = msg_data_q;
  assign err_checksum = err_checksum_q;
  assign err_length   = err_length_q;
  assign err_timeout  = err_timeout_q;
  assign busy         = (state_q != RX_IDLE);

`ifdef ANT_RX_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (msg_valid_q && (good_cnt_q != 16'hFFFF)) good_cnt_d = good_cnt_q + 16'd1;
    if ((err_checksum_q || err_length_q || err_timeout_q) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge c50m or negedge nRST) begin
    if (!nRST) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign good_count = good_cnt_q;
  assign err_count  = err_cnt_q;
`else
  assign good_count = 16'd0;
  assign err_count  = 16'd0;
`endif

endmodule

// File: tb/tb_ant_rx_parser.sv
// Directed and randomized bench for ant_rx_parser against a packet-level model.
module tb_ant_rx_parser;
  localparam int MAX_LEN = 13;
  localparam int TO      = 40;

  logic                 c50m = 1'b0;
  logic                 nRST = 1'b0;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic                 msg_valid, err_checksum, err_length, err_timeout, busy;
  logic [7:0]           msg_id, msg_len;
  logic [MAX_LEN*8-1:0] msg_data;
  logic [15:0]          good_count, err_count;

  ant_rx_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .c50m(c50m), .nRST(nRST), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .msg_valid(msg_valid), .msg_id(msg_id), .msg_len(msg_len), .msg_data(msg_data),
    .err_checksum(err_checksum), .err_length(err_length), .err_timeout(err_timeout),
    .busy(busy), .good_count(good_count), .err_count(err_count)
  );

  always #10 c50m = ~c50m;

  int errors = 0;
  int checks = 0;

  // Model state: last accepted message and statistics.
  logic [7:0] exp_id = 8'h00, exp_len = 8'h00;
  logic [7:0] exp_bytes[MAX_LEN];
  int exp_good = 0, exp_err = 0;

  // Candidate packet being sent.
  logic [7:0] q[$];
  logic [7:0] pay_id, pay_len;
  logic [7:0] pay[MAX_LEN];
  int gap_max = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAX_LEN*8-1:0] exp_data();
    logic [MAX_LEN*8-1:0] v = '0;
    for (int k = 0; k < MAX_LEN; k++) v[k*8 +: 8] = exp_bytes[k];
    return v;
  endfunction

  task automatic model_clear();
    exp_id = 8'h00; exp_len = 8'h00; exp_good = 0; exp_err = 0;
    for (int k = 0; k < MAX_LEN; k++) exp_bytes[k] = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, gap_max)) @(negedge c50m);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge c50m);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic chk_msg(input string tag);
    chk({tag, ".id"},   128'(msg_id),   128'(exp_id));
    chk({tag, ".len"},  128'(msg_len),  128'(exp_len));
    chk({tag, ".data"}, 128'(msg_data), 128'(exp_data()));
  endtask

  // kind: 0 none expected, 1 msg_valid, 2 err_checksum, 3 err_length (on last byte)
  task automatic send_q(input string tag, input int kind, input logic exp_busy);
    for (int i = 0; i < q.size(); i++) begin
      logic last;
      send_byte(q[i]);
      last = (i == q.size() - 1);
      chk({tag, ".msg_valid"},    128'(msg_valid),    128'(last && kind == 1));
      chk({tag, ".err_checksum"}, 128'(err_checksum), 128'(last && kind == 2));
      chk({tag, ".err_length"},   128'(err_length),   128'(last && kind == 3));
      chk({tag, ".err_timeout"},  128'(err_timeout),  128'(0));
    end
    if (kind == 1) begin
      exp_id = pay_id; exp_len = pay_len;
      for (int k = 0; k < MAX_LEN; k++) exp_bytes[k] = (k < int'(pay_len)) ? pay[k] : 8'h00;
      exp_good++;
    end else if (kind != 0) begin
      exp_err++;
    end
    chk_msg(tag);
    chk({tag, ".busy"}, 128'(busy), 128'(exp_busy));
    q.delete();
  endtask

  task automatic set_pay(input logic [7:0] id, input logic [7:0] len, input logic [7:0] d0);
    pay_id = id; pay_len = len;
    for (int k = 0; k < MAX_LEN; k++) pay[k] = 8'h00;
    pay[0] = d0;
  endtask

  task automatic chk_stats(input string tag);
    @(negedge c50m);
`ifdef ANT_RX_STATS_EN
    chk({tag, ".good_count"}, 128'(good_count), 128'(exp_good));
    chk({tag, ".err_count"},  128'(err_count),  128'(exp_err));
`else
    chk({tag, ".good_count"}, 128'(good_count), 128'(0));
    chk({tag, ".err_count"},  128'(err_count),  128'(0));
`endif
  endtask

  initial begin
    model_clear();
    // Reset state
    repeat (3) @(negedge c50m);
    chk("rst.msg_valid", 128'(msg_valid), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.errs", 128'({err_checksum, err_length, err_timeout}), 128'(0));
    chk_msg("rst");
    nRST = 1'b1;
    repeat (2) @(negedge c50m);

    // Good one-byte packet
    set_pay(8'h4A, 8'd1, 8'h00);
    q = '{8'hA4, 8'h01, 8'h4A, 8'h00, 8'hEF};
    send_q("good1", 1, 1'b0);

    // Bad checksum keeps the previous message
    q = '{8'hA4, 8'h01, 8'h4A, 8'h00, 8'hEE};
    send_q("badcs", 2, 1'b0);

    // Leading garbage ignored, zero-length message
    set_pay(8'h6F, 8'd0, 8'h00);
    q = '{8'h55, 8'h12, 8'hA4, 8'h00, 8'h6F, 8'hCB};
    send_q("zlen", 1, 1'b0);

    // Over-long length, then recovery
    q = '{8'hA4, 8'h0E};
    send_q("badlen", 3, 1'b0);
    set_pay(8'h4A, 8'd1, 8'h00);
    q = '{8'hA4, 8'h01, 8'h4A, 8'h00, 8'hEF};
    send_q("afterlen", 1, 1'b0);
    chk_stats("stats1");

    // Timeout after a stalled packet
    q = '{8'hA4, 8'h01};
    send_q("to.start", 0, 1'b1);
    begin
      int n_to = 0;
      int n_other = 0;
      for (int c = 0; c < 3 * TO; c++) begin
        @(negedge c50m);
        if (err_timeout) n_to++;
        if (msg_valid || err_checksum || err_length) n_other++;
      end
      chk("to.count", 128'(n_to), 128'(1));
      chk("to.other", 128'(n_other), 128'(0));
      chk("to.busy", 128'(busy), 128'(0));
      exp_err++;
    end
    q = '{8'hA4, 8'h01, 8'h4A, 8'h00, 8'hEF};
    send_q("to.after", 1, 1'b0);

    // Byte arriving exactly on the expiry cycle wins
    q = '{8'hA4};
    send_q("edge.start", 0, 1'b1);
    for (int c = 0; c < TO - 1; c++) begin
      @(negedge c50m);
      chk("edge.idle_to", 128'(err_timeout), 128'(0));
    end
    set_pay(8'h4E, 8'd1, 8'h5A);
    q = '{8'h01, 8'h4E, 8'h5A, 8'hA4 ^ 8'h01 ^ 8'h4E ^ 8'h5A};
    send_q("edge.pkt", 1, 1'b0);

    // Reset mid-packet drops it silently
    q = '{8'hA4, 8'h01, 8'h4A};
    send_q("mrst.start", 0, 1'b1);
    nRST = 1'b0;
    model_clear();
    @(negedge c50m);
    chk("mrst.busy", 128'(busy), 128'(0));
    chk("mrst.pulses", 128'({msg_valid, err_checksum, err_length, err_timeout}), 128'(0));
    chk_msg("mrst");
    nRST = 1'b1;
    repeat (2) @(negedge c50m);
    chk("mrst.pulses2", 128'({msg_valid, err_checksum, err_length, err_timeout}), 128'(0));
    set_pay(8'h4A, 8'd1, 8'h00);
    q = '{8'hA4, 8'h01, 8'h4A, 8'h00, 8'hEF};
    send_q("mrst.after", 1, 1'b0);
    chk_stats("stats2");

    // Randomized packets with gaps, garbage and corruption
    gap_max = 3;
    for (int p = 0; p < 40; p++) begin
      int r, kind;
      logic [7:0] cs;
      r = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA4) g = 8'h00;
        q.push_back(g);
      end
      q.push_back(8'hA4);
      if (r >= 8) begin
        q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        kind = 3;
      end else begin
        pay_len = 8'($urandom_range(0, MAX_LEN));
        pay_id  = 8'($urandom);
        cs = 8'hA4 ^ pay_len ^ pay_id;
        q.push_back(pay_len);
        q.push_back(pay_id);
        for (int k = 0; k < MAX_LEN; k++) begin
          pay[k] = 8'($urandom);
          if (k < int'(pay_len)) begin
            q.push_back(pay[k]);
            cs = cs ^ pay[k];
          end
        end
        if (r >= 6) begin
          cs = cs ^ 8'($urandom_range(1, 255));
          kind = 2;
        end else begin
          kind = 1;
        end
        q.push_back(cs);
      end
      send_q("rnd", kind, 1'b0);
    end
    chk_stats("stats3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ant_rx_parser.md
ANT_RX_PARSER -- requirements
Module: ant_rx_parser

Interface
REQ-001 Parameter MAX_LEN, default 13: largest accepted payload length in bytes.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000: allowed idle clocks between bytes inside a packet (100 ms at 50 MHz).
REQ-003 c50m  in  1  system clock; all logic on its rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 rx_valid  in  1  one-cycle strobe from the UART receiver; a byte is ready.
REQ-006 rx_byte  in  8  received byte; sampled only when rx_valid=1.
REQ-007 msg_valid  out  1  one-cycle pulse; a good message has been captured.
REQ-008 msg_id  out  8  message ID of the last good message.
REQ-009 msg_len  out  8  payload length of the last good message.
REQ-010 msg_data  out  MAX_LEN*8  payload; byte k is at [8k+7:8k]; bytes at or above msg_len are 0.
REQ-011 err_checksum, err_length, err_timeout  out  1 each  one-cycle error pulses.
REQ-012 busy  out  1  high when the FSM is not in IDLE.
REQ-013 good_count, err_count  out  16 each  statistics counters (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, LEN, ID, DATA, CSUM and advance only on cycles where rx_valid=1.
REQ-015 IDLE: 0xA4 moves to LEN, sets the running XOR to 0xA4, clears the data buffer; any other byte is discarded silently.
REQ-016 LEN: a value above MAX_LEN pulses err_length and returns to IDLE; otherwise store it and go to ID.
REQ-017 ID: store the ID; go to DATA if length>0, else go to CSUM.
REQ-018 DATA: store the byte at the index counter and increment the index; after byte length-1, go to CSUM.
REQ-019 Running XOR SHALL include the sync, length, ID and data bytes.
REQ-020 CSUM: if the byte equals the running XOR, update msg_id, msg_len and msg_data, pulse msg_valid, and return to IDLE.
REQ-021 CSUM: on mismatch, pulse err_checksum, leave the msg_* outputs unchanged, and return to IDLE.
REQ-022 msg_valid SHALL assert on the cycle after the checksum byte's rx_valid cycle; the msg_* outputs SHALL hold until the next good message.
REQ-023 Timeout counter: cleared on every rx_valid and while in IDLE.
REQ-024 Timeout: when busy and the counter reaches TIMEOUT_CYCLES-1, pulse err_timeout and go to IDLE.
REQ-025 If rx_valid and timeout expiry occur in the same cycle, rx_valid wins: the byte is processed and there is no timeout.
REQ-026 A 0xA4 byte received mid-packet SHALL be treated as ordinary content; there is no resynchronisation.
REQ-027 At most one of msg_valid, err_checksum, err_length and err_timeout SHALL be high in any cycle.

Reset
REQ-028 nRST low SHALL immediately force IDLE and clear the XOR, index, timeout counter, msg_*, data buffer, all pulses and both statistics counters.
REQ-029 A packet in progress when reset asserts SHALL be dropped without any error pulse.

Configuration
REQ-030 Macro ANT_RX_STATS_EN defined: good_count increments on each msg_valid and err_count on each error pulse; both saturate at 0xFFFF.
REQ-031 Macro ANT_RX_STATS_EN undefined: both ports remain present, are tied to 0, and no counter logic is built.

Structure
REQ-032 Shared package ant_pkg SHALL hold MESG_TX_SYNC (8'hA4), the MESG_*_ID constants, and the state enum typedef ant_rx_state_t.
REQ-033 The timeout counter SHALL be one sub-module, ant_rx_timeout (clear, enable, expire outputs); all other logic stays in ant_rx_parser.

Verification
REQ-034 Bytes A4 01 4A 00 EF -> one msg_valid; msg_id=4A, msg_len=1, msg_data[7:0]=00.
REQ-035 Bytes A4 01 4A 00 EE -> err_checksum pulse; no msg_valid; previous msg_* values unchanged.
REQ-036 Bytes 55 12 A4 00 6F CB -> the first two bytes are ignored; msg_valid with msg_id=6F, msg_len=0.
REQ-037 Bytes A4 0E -> err_length immediately after 0E; then A4 01 4A 00 EF -> msg_valid.
REQ-038 Bytes A4 01, then 5000000 idle cycles -> exactly one err_timeout and busy=0; a following good packet is accepted.
REQ-039 nRST pulse after A4 01 4A -> no pulses; then A4 01 4A 00 EF -> msg_valid; counters reflect the run when ANT_RX_STATS_EN is defined.
